matmul_sequencer: RTL and testbench

Sequencer for the matrix-multiply datapath. After `control_unit` has loaded matrices A and B into the matrix memories, it asserts `start`. This block then walks the row/column/inner-product indices and drives the A/B read addresses. It accumulates the products of the returned operands and writes each result element into the result memory. It sits between `control_unit` (start, size, done) and the `matrix_memory` instances, on the system clock, and replaces the stub multiplier.

---
 rtl/matmul_sequencer.sv | 105 ++++++++++
 tb/tb_matmul_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks i/j/k indices over A/B memories, accumulates dot products
// and writes each C element; one MAC pass of N+1 cycles plus one write cycle per element.
module matmul_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int MAX_N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] result_addr,
  output logic [DATA_W-1:0] result_data,
  output logic              result_we,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, MAC, WRITE, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [3:0] n_q, n_d, i_q, i_d, j_q, j_d, c_q, c_d;
  logic [DATA_W-1:0] acc_q, acc_d, prod;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic last_col, last_row;
  always_comb begin
    prod = a_data * b_data;
    last_col = j_q == n_q - 4'd1;
    last_row = i_q == n_q - 4'd1;
    state_d = state_q;
    n_d = n_q;
    i_d = i_q;
    j_d = j_q;
    c_d = c_q;
    acc_d = acc_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    case (state_q)
      IDLE: if (start) begin
        if (matrix_size == 4'd0 || matrix_size > 4'(MAX_N)) state_d = ERR;
        else begin
          state_d = MAC;
          n_d = matrix_size;
          i_d = 4'd0;
          j_d = 4'd0;
          c_d = 4'd0;
          a_addr_d = '0;
          b_addr_d = '0;
        end
      end
      MAC: begin
        c_d = c_q + 4'd1;
        // operands for index c arrive one cycle after their address, hence the c-1 lag
        acc_d = (c_q == 4'd1) ? prod : (c_q > 4'd1) ? acc_q + prod : acc_q;
        if (c_q + 4'd1 < n_q) begin
          a_addr_d = ADDR_W'(i_q * n_q + c_q + 4'd1);
          b_addr_d = ADDR_W'((c_q + 4'd1) * n_q + j_q);
        end
        if (c_q == n_q) state_d = WRITE;
      end
      WRITE: if (last_col && last_row) state_d = DONE;
      else begin
        state_d = MAC;
        j_d = last_col ? 4'd0 : j_q + 4'd1;
        i_d = last_col ? i_q + 4'd1 : i_q;
        c_d = 4'd0;
        a_addr_d = ADDR_W'(i_d * n_q);
        b_addr_d = ADDR_W'(j_d);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= 4'd0;
      i_q <= 4'd0;
      j_q <= 4'd0;
      c_q <= 4'd0;
      acc_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      i_q <= i_d;
      j_q <= j_d;
      c_q <= c_d;
      acc_q <= acc_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  end
  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign result_we = state_q == WRITE;
  assign result_addr = result_we ? ADDR_W'(i_q * n_q + j_q) : '0;
  assign result_data = result_we ? acc_q : '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE || state_q == ERR;
  assign err = state_q == ERR;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: random and directed jobs against a cycle-indexed behavioural model.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] matrix_size;
  logic [3:0] a_addr, b_addr, result_addr;
  logic [31:0] a_data, b_data, result_data;
  logic result_we, busy, done, err;
  bit [31:0] amem [16];
  bit [31:0] bmem [16];
  int checks = 0, errors = 0;
  int m_cyc, m_n, m_dcyc;
  bit m_act, m_legal;
  logic [31:0] m_c [16];
  logic [31:0] cap_data [16];
  int cap_cyc [16];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0;
  int cmp_e, cmp_p;
  bit exp_we, exp_done;
  int sz;
  bit sz_ok;

  matmul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .result_addr(result_addr), .result_data(result_data), .result_we(result_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= amem[a_addr];
    b_data <= bmem[b_addr];
  end

  function automatic logic [31:0] dot(int n, int i, int j);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) s = s + amem[i*n+k] * bmem[k*n+j];
    return s;
  endfunction

  assign sz = int'(matrix_size);
  assign sz_ok = sz >= 1 && sz <= 4;

  // Model: cycle index since the accepted start; element e written at (e+1)*(N+2)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_cyc <= 0;
    end else if (m_act) begin
      m_cyc <= m_cyc + 1;
      if (m_cyc == m_dcyc) m_act <= 1'b0;
    end else if (start) begin
      m_act <= 1'b1;
      m_cyc <= 1;
      m_n <= sz;
      m_legal <= sz_ok;
      m_dcyc <= sz_ok ? sz*sz*(sz+2) + 1 : 1;
      for (int e = 0; e < 16; e++) m_c[e] <= (sz_ok && e < sz*sz) ? dot(sz, e/sz, e%sz) : 32'd0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input int n, input bit hold, input bit chg);
    int k = 0;
    start = 1'b1;
    matrix_size = 4'(n);
    do begin
      @(negedge clk); #1;
      k++;
      if (chg && m_cyc == 2) matrix_size = 4'd3;
      if (!hold || m_cyc == m_dcyc) start = 1'b0;
    end while (m_act && k < 300);
    if (m_act) chk("job_timeout", 64'(k), 64'(0));
    start = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic load_2x2();
    for (int e = 0; e < 4; e++) begin
      amem[e] = 32'(e + 1);
      bmem[e] = 32'(e + 5);
    end
  endtask

  task automatic chk_2x2();
    chk("c0", 64'(cap_data[0]), 64'd19);
    chk("c1", 64'(cap_data[1]), 64'd22);
    chk("c2", 64'(cap_data[2]), 64'd43);
    chk("c3", 64'(cap_data[3]), 64'd50);
  endtask

  initial begin
    int w0, d0, e0;
    rst = 1'b1;
    start = 1'b0;
    matrix_size = 4'd0;
    fork
      forever begin
        @(negedge clk);
        exp_we = m_act && m_legal && m_cyc % (m_n + 2) == 0 && m_cyc < m_dcyc;
        exp_done = m_act && m_cyc == m_dcyc;
        cmp_e = exp_we ? m_cyc / (m_n + 2) - 1 : 0;
        chk("we", 64'(result_we), 64'(exp_we));
        chk("done", 64'(done), 64'(exp_done));
        chk("err", 64'(err), 64'(exp_done && !m_legal));
        chk("busy", 64'(busy), 64'(m_act));
        chk("raddr", 64'(result_addr), exp_we ? 64'(cmp_e) : 64'd0);
        chk("rdata", 64'(result_data), exp_we ? 64'(m_c[cmp_e]) : 64'd0);
        if (m_act && m_legal && m_cyc < m_dcyc) begin
          cmp_p = (m_cyc - 1) % (m_n + 2);
          cmp_e = (m_cyc - 1) / (m_n + 2);
          if (cmp_p < m_n) begin
            chk("a_addr", 64'(a_addr), 64'((cmp_e / m_n) * m_n + cmp_p));
            chk("b_addr", 64'(b_addr), 64'(cmp_p * m_n + cmp_e % m_n));
          end
        end
        if (result_we) begin
          cap_data[result_addr] = result_data;
          cap_cyc[result_addr] = m_cyc;
          wr_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = m_cyc;
          if (err) err_cnt++;
        end
      end
    join_none
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 64'({a_addr, b_addr, result_addr, result_data, result_we, busy, done, err}), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    load_2x2();
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    run_job(2, 1'b0, 1'b0);
    chk_2x2();
    for (int e = 0; e < 4; e++) chk("c_cyc", 64'(cap_cyc[e]), 64'(4 * (e + 1)));
    chk("done_cyc_2", 64'(done_cyc), 64'd17);
    chk("err_2", 64'(err_cnt - e0), 64'd0);
    chk("wr_2", 64'(wr_cnt - w0), 64'd4);

    amem[0] = 32'd3; bmem[0] = 32'd4;
    run_job(1, 1'b0, 1'b0);
    chk("c_1x1", 64'(cap_data[0]), 64'd12);
    chk("cyc_1x1", 64'(cap_cyc[0]), 64'd3);
    chk("done_cyc_1", 64'(done_cyc), 64'd4);

    for (int e = 0; e < 16; e++) begin
      amem[e] = $urandom;
      bmem[e] = (e % 5 == 0) ? 32'd1 : 32'd0;
    end
    run_job(4, 1'b0, 1'b0);
    for (int e = 0; e < 16; e++) chk("identity", 64'(cap_data[e]), 64'(amem[e]));
    chk("done_cyc_4", 64'(done_cyc), 64'd97);

    amem[0] = 32'hFFFF_FFFF; bmem[0] = 32'd2;
    run_job(1, 1'b0, 1'b0);
    chk("wrap_1", 64'(cap_data[0]), 64'hFFFF_FFFE);
    for (int e = 0; e < 4; e++) begin
      amem[e] = 32'h8000_0000;
      bmem[e] = 32'h8000_0000;
    end
    run_job(2, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) chk("wrap_2", 64'(cap_data[e]), 64'd0);

    for (int s = 0; s < 2; s++) begin
      w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
      run_job(s == 0 ? 0 : 5, 1'b0, 1'b0);
      chk("ill_done_cyc", 64'(done_cyc), 64'd1);
      chk("ill_err", 64'(err_cnt - e0), 64'd1);
      chk("ill_wr", 64'(wr_cnt - w0), 64'd0);
    end

    load_2x2();
    w0 = wr_cnt; d0 = done_cnt;
    run_job(2, 1'b1, 1'b1);
    chk("hold_wr", 64'(wr_cnt - w0), 64'd4);
    chk("hold_done", 64'(done_cnt - d0), 64'd1);
    chk_2x2();

    w0 = wr_cnt; d0 = done_cnt;
    start = 1'b1;
    matrix_size = 4'd2;
    for (int k = 0; k < 50 && m_cyc != 6; k++) begin
      @(negedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", 64'({a_addr, b_addr, result_addr, result_data, result_we, busy, done, err}), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_mid_wr", 64'(wr_cnt - w0), 64'd1);
    chk("rst_mid_done", 64'(done_cnt - d0), 64'd0);
    run_job(2, 1'b0, 1'b0);
    chk_2x2();

    for (int r = 0; r < 10; r++) begin
      for (int e = 0; e < 16; e++) begin
        amem[e] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 9));
        bmem[e] = $urandom;
      end
      run_job(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
